// File: rtl/sobel_window_gen.sv
// sobel_window_gen
//   Streaming 3x3 window generator for the Sobel convolution stage. Accepts
//   one 12-bit unsigned pixel per pix_valid cycle in raster order, keeps the
//   two previous image lines in line buffers, and presents the 3x3
//   neighbourhood as nine zero-extended 13-bit signed taps.
//
// Ports
//   clk         clock
//   rst         synchronous reset, active-low; wins over sof and pix_valid
//   sof         marks the pixel on pix_in as (0,0); sampled with pix_valid
//   pix_in      12-bit unsigned pixel
//   pix_valid   pixel strobe, one pixel per high cycle, no backpressure
//   row_i_j     window taps: row 0 = oldest line, column 2 = newest pixel
//   win_valid   taps hold a complete 3x3 window (one cycle after pixel)
//   frame_done  one-cycle pulse with the window of the frame's last pixel
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sof,
  input  logic [11:0]        pix_in,
  input  logic               pix_valid,
  output logic signed [12:0] row_0_0,
  output logic signed [12:0] row_0_1,
  output logic signed [12:0] row_0_2,
  output logic signed [12:0] row_1_0,
  output logic signed [12:0] row_1_1,
  output logic signed [12:0] row_1_2,
  output logic signed [12:0] row_2_0,
  output logic signed [12:0] row_2_1,
  output logic signed [12:0] row_2_2,
  output logic               win_valid,
  output logic               frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0] col, col_eff, col_next;
  logic [RW-1:0] row, row_eff, row_next;
  logic          last_col, last_row;

  // Two line buffers: lb1 holds the previous line, lb0 the line above it.
  logic [11:0] lb0 [IMG_WIDTH];
  logic [11:0] lb1 [IMG_WIDTH];
  logic [11:0] lb0_rd, lb1_rd;

  // 3x3 window, win[row][col]; column 2 is the newest pixel.
  logic [11:0] win [3][3];

  // Position of the pixel being accepted: sof forces (0,0) whatever the
  // counters say, which also abandons a partially received frame.
  // NOTE: every always_comb output gets a value on every path (here by
  // assigning defaults first) so no latch is inferred.
  always_comb begin
    col_eff  = col;
    row_eff  = row;
    if (sof) begin
      col_eff = '0;
      row_eff = '0;
    end
    last_col = (col_eff == CW'(IMG_WIDTH - 1));
    last_row = (row_eff == RW'(IMG_HEIGHT - 1));
    col_next = col_eff + CW'(1);
    row_next = row_eff;
    if (last_col) begin
      col_next = '0;
      row_next = last_row ? '0 : row_eff + RW'(1);
    end
    lb0_rd = lb0[col_eff];
    lb1_rd = lb1[col_eff];
  end

  // Line buffers are read combinationally above (old contents) and written
  // here, giving read-before-write behaviour at the same address.
  // NOTE: the buffer memories are deliberately not reset; stale data is
  // harmless because win_valid is gated by the row/column counters, and
  // leaving them unreset lets them map onto block RAM.
  always_ff @(posedge clk) begin
    if (rst && pix_valid) begin
      lb0[col_eff] <= lb1_rd;
      lb1[col_eff] <= pix_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else begin
      win_valid  <= pix_valid && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
      frame_done <= pix_valid && last_row && last_col;
      if (pix_valid) begin
        col <= col_next;
        row <= row_next;
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb0_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= pix_in;
      end
    end
  end

  // Zero-extension keeps every tap non-negative in the signed datapath.
  assign row_0_0 = {1'b0, win[0][0]};
  assign row_0_1 = {1'b0, win[0][1]};
  assign row_0_2 = {1'b0, win[0][2]};
  assign row_1_0 = {1'b0, win[1][0]};
  assign row_1_1 = {1'b0, win[1][1]};
  assign row_1_2 = {1'b0, win[1][2]};
  assign row_2_0 = {1'b0, win[2][0]};
  assign row_2_1 = {1'b0, win[2][1]};
  assign row_2_2 = {1'b0, win[2][2]};

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen
//   Directed bench for sobel_window_gen at 4x4: a plain frame, a frame with
//   idle gaps, back-to-back frames with inverted pixel values, a frame
//   aborted by sof, and a mid-frame reset followed by a restart without sof.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               sof = 1'b0;
  logic               pix_valid = 1'b0;
  logic [11:0]        pix_in = '0;
  logic signed [12:0] row_0_0, row_0_1, row_0_2;
  logic signed [12:0] row_1_0, row_1_1, row_1_2;
  logic signed [12:0] row_2_0, row_2_1, row_2_2;
  logic               win_valid, frame_done;

  int total = 0;
  int bad   = 0;
  int win_cnt;
  int fd_cnt;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .row_0_0    (row_0_0),
    .row_0_1    (row_0_1),
    .row_0_2    (row_0_2),
    .row_1_0    (row_1_0),
    .row_1_1    (row_1_1),
    .row_1_2    (row_1_2),
    .row_2_0    (row_2_0),
    .row_2_1    (row_2_1),
    .row_2_2    (row_2_2),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // kind 0: 16r+c, kind 1: 4095-(16r+c)
  function automatic logic [11:0] pix(int kind, int r, int c);
    int v;
    v = 16 * r + c;
    if (kind != 0) v = 4095 - v;
    return 12'(v);
  endfunction

  function automatic logic [38:0] row_obs(int i);
    case (i)
      0:       return {row_0_0, row_0_1, row_0_2};
      1:       return {row_1_0, row_1_1, row_1_2};
      default: return {row_2_0, row_2_1, row_2_2};
    endcase
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Three taps packed as three 13-bit values, for hand-written constants.
  function automatic logic [38:0] taps(int a, int b, int c);
    return {13'(a), 13'(b), 13'(c)};
  endfunction

  task automatic check_window(string tag, int kind, int r, int c);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s r%0d c%0d row%0d", tag, r, c, i), 64'(row_obs(i)),
            64'(taps(pix(kind, r - 2 + i, c - 2), pix(kind, r - 2 + i, c - 1),
                     pix(kind, r - 2 + i, c))));
  endtask

  // Drive one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step(logic v, logic s, logic [11:0] p);
    pix_valid = v;
    sof       = s;
    pix_in    = p;
    @(posedge clk);
    #1;
  endtask

  task automatic send(int kind, int r, int c, logic s);
    logic exp_win;
    exp_win = (r >= 2) && (c >= 2);
    step(1'b1, s, pix(kind, r, c));
    if (win_valid)  win_cnt++;
    if (frame_done) fd_cnt++;
    check($sformatf("win_valid r%0d c%0d", r, c), 64'(win_valid), 64'(exp_win));
    check($sformatf("frame_done r%0d c%0d", r, c), 64'(frame_done),
          64'((r == H - 1) && (c == W - 1)));
    if (exp_win) check_window("taps", kind, r, c);
  endtask

  task automatic gap(int kind, int r, int c);
    step(1'b0, 1'b0, 12'hFFF);
    if (win_valid)  win_cnt++;
    if (frame_done) fd_cnt++;
    check("gap win_valid", 64'(win_valid), 64'd0);
    check("gap frame_done", 64'(frame_done), 64'd0);
    if ((r >= 2) && (c >= 2)) check_window("gap hold", kind, r, c);
  endtask

  task automatic run_frame(int kind, bit gaps, bit use_sof);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(kind, r, c, use_sof && (r == 0) && (c == 0));
        if (gaps) gap(kind, r, c);
      end
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 12'h123);
    for (int i = 0; i < 3; i++) check("reset taps", 64'(row_obs(i)), 64'd0);
    check("reset win_valid", 64'(win_valid), 64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);
    rst = 1'b1;

    // Scenario 1: continuous frame
    win_cnt = 0; fd_cnt = 0;
    run_frame(0, 1'b0, 1'b1);
    check("s1 last row0", 64'(row_obs(0)), 64'(taps(17, 18, 19)));
    check("s1 last row1", 64'(row_obs(1)), 64'(taps(33, 34, 35)));
    check("s1 last row2", 64'(row_obs(2)), 64'(taps(49, 50, 51)));
    check("s1 windows", 64'(win_cnt), 64'd4);
    check("s1 frame_done", 64'(fd_cnt), 64'd1);

    // Scenario 2: idle cycle after every pixel
    win_cnt = 0; fd_cnt = 0;
    run_frame(0, 1'b1, 1'b1);
    check("s2 windows", 64'(win_cnt), 64'd4);
    check("s2 frame_done", 64'(fd_cnt), 64'd1);

    // Scenario 3: back-to-back frames, second inverted
    win_cnt = 0; fd_cnt = 0;
    run_frame(0, 1'b0, 1'b1);
    send(1, 0, 0, 1'b1);
    for (int i = 1; i < 11; i++) send(1, i / W, i % W, 1'b0);
    check("s3 first row0", 64'(row_obs(0)), 64'(taps(4095, 4094, 4093)));
    check("s3 first row1", 64'(row_obs(1)), 64'(taps(4079, 4078, 4077)));
    check("s3 first row2", 64'(row_obs(2)), 64'(taps(4063, 4062, 4061)));
    check("s3 tap sign", 64'(row_0_0 > 0), 64'd1);
    for (int i = 11; i < W * H; i++) send(1, i / W, i % W, 1'b0);
    check("s3 last row2", 64'(row_obs(2)), 64'(taps(4046, 4045, 4044)));
    check("s3 windows", 64'(win_cnt), 64'd8);
    check("s3 frame_done", 64'(fd_cnt), 64'd2);

    // Scenario 4: sof at what would be pixel (2,1) aborts the frame
    win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 9; i++) send(1, i / W, i % W, i == 0);
    run_frame(0, 1'b0, 1'b1);
    check("s4 windows", 64'(win_cnt), 64'd4);
    check("s4 frame_done", 64'(fd_cnt), 64'd1);

    // Scenario 5: reset after pixel (2,2), restart without sof
    for (int i = 0; i < 11; i++) send(0, i / W, i % W, i == 0);
    check("s5 first row0", 64'(row_obs(0)), 64'(taps(0, 1, 2)));
    check("s5 first row1", 64'(row_obs(1)), 64'(taps(16, 17, 18)));
    check("s5 first row2", 64'(row_obs(2)), 64'(taps(32, 33, 34)));
    rst = 1'b0;
    step(1'b1, 1'b1, 12'hABC);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) check("s5 reset taps", 64'(row_obs(i)), 64'd0);
    check("s5 reset win_valid", 64'(win_valid), 64'd0);
    check("s5 reset frame_done", 64'(frame_done), 64'd0);
    win_cnt = 0; fd_cnt = 0;
    run_frame(1, 1'b0, 1'b0);
    check("s5 windows", 64'(win_cnt), 64'd4);
    check("s5 frame_done", 64'(fd_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator feeding the Sobel convolution stage. Accepts one unsigned 12-bit grayscale pixel per valid cycle in raster order, keeps two full image lines in internal line buffers, and presents the 3x3 neighbourhood as nine 13-bit signed (zero-extended) taps plus a window-valid strobe. It sits between the pixel source (camera/frame reader) and the convolution block; its `row_i_j` outputs wire directly to the convolution inputs of the same names.

## Interface
- `IMG_WIDTH`, 640: pixels per line, ≥ 3
- `IMG_HEIGHT`, 480: lines per frame, ≥ 3
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `sof`  in  1  start of frame; qualifies the pixel on `pix_in` as pixel (0,0); only sampled when `pix_valid`=1
- `pix_in`  in  12  unsigned pixel
- `pix_valid`  in  1  pixel strobe; one pixel accepted per cycle it is high; no backpressure
- `row_0_0` … `row_2_2`  out  13 each (signed)  window taps; row 0 = oldest line (top), row 2 = current line; column 0 = leftmost (oldest), column 2 = newest pixel
- `win_valid`  out  1  taps hold a complete 3x3 window this cycle
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) give the position of the pixel being accepted; they advance only on `pix_valid`.
- `col` wraps from IMG_WIDTH-1 to 0 and increments `row`; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
- `sof`=1 with `pix_valid`=1: the pixel is accepted at (0,0) regardless of counter state; counters then advance to (0,1). A mid-frame `sof` abandons the current frame; no `frame_done` for it.
- Line buffers LB1 (previous line) and LB0 (two lines up), depth IMG_WIDTH × 12 bits, addressed by `col`. On an accepted pixel: read LB0[col], LB1[col] (read-before-write), then LB0[col] ← old LB1[col], LB1[col] ← `pix_in`.
- 3x3 shift register: on an accepted pixel each row shifts left (col0 ← col1, col1 ← col2); the new col2 entries are row0 ← old LB0[col], row1 ← old LB1[col], row2 ← `pix_in`.
- Taps are zero-extended: `row_i_j` = {1'b0, pixel}; range 0..4095, never negative.
- Line-buffer contents are not cleared by reset or `sof`; stale data never escapes because `win_valid` is gated by the counters.
- `win_valid` is high for the window of accepted pixel (r,c) iff r ≥ 2 and c ≥ 2; that window contains pixels (r-2..r, c-2..c). No windows straddle a line wrap. Exactly (IMG_WIDTH-2)·(IMG_HEIGHT-2) windows per frame.

## Timing
- Latency: taps and `win_valid` are registered; they are valid the cycle after the accepted pixel (r,c).
- `pix_valid`=0: counters, buffers and taps hold; `win_valid`=0 and `frame_done`=0 that cycle.
- `frame_done` is asserted in the same cycle as the final `win_valid` of the frame (after pixel (H-1,W-1) is accepted).
- Back-to-back frames with no idle cycle are supported; the next frame's pixel (0,0) may arrive the cycle after (H-1,W-1).
- Reset (rst=0, sampled on clk): `col`, `row` ← 0; all nine taps ← 0; `win_valid`, `frame_done` ← 0. Reset mid-frame abandons the frame; the first pixel after reset is (0,0) with or without `sof`.
- `rst`=0 has priority over `pix_valid` and `sof` in the same cycle.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=4, continuous `pix_valid`, pixel(r,c)=16r+c, `sof` on (0,0) -> exactly 4 `win_valid` cycles; first window after pixel (2,2): row_0_*=0,1,2; row_1_*=16,17,18; row_2_*=32,33,34; `frame_done` with the 4th window (taps 17,18,19 / 33,34,35 / 49,50,51).
- Same frame with `pix_valid` deasserted every other cycle -> identical window sequence and values; taps hold during gaps; `win_valid` never high in a gap cycle.
- Two frames back-to-back, second with pixel = 4095 - (16r+c) -> second frame's first window is 4095,4094,4093 / 4079,4078,4077 / 4063,4062,4061, all positive 13-bit values; 8 windows total, 2 `frame_done` pulses.
- `sof` asserted at pixel (2,1) of frame 1, then a full frame -> no `frame_done` for the aborted frame; new frame yields exactly 4 windows, with the same values as scenario 1.
- `rst`=0 for one cycle after pixel (2,2) -> all outputs 0 the following cycle; restart without `sof` -> first `win_valid` only after 11 new pixels, with fresh values.
- Default parameters (640x480), random pixels -> 638·478 = 304,964 windows; every window matches a software 3x3 reference model.
